// File: rtl/ex_pkg.sv
// ex_pkg: shared definitions for the execute-stage destination controller.
//   ex_state_t  - FSM state encoding (IDLE/RUN/MD_WAIT/MD_DONE)
//   REG_W_DEF   - default register-index width
//   ZERO_REG    - architectural $0 index (writes to it are discarded)
package ex_pkg;
  localparam int REG_W_DEF = 5;

  typedef logic [1:0] ex_state_t;
  localparam ex_state_t ST_IDLE    = 2'd0;
  localparam ex_state_t ST_RUN     = 2'd1;
  localparam ex_state_t ST_MD_WAIT = 2'd2;
  localparam ex_state_t ST_MD_DONE = 2'd3;

  localparam logic [REG_W_DEF-1:0] ZERO_REG = '0;
endpackage

// File: rtl/ex_md_timer.sv
// ex_md_timer: saturating cycle counter for an outstanding mult/div.
//   clk, rst_n  - clock, async active-low reset
//   start_i     - load 1 (the md_start cycle is cycle 1 of the wait)
//   clr_i       - clear to 0 (wait finished or aborted)
//   en_i        - count one more wait cycle
//   expired_o   - current wait cycle is the LIMIT-th one
module ex_md_timer #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);
  import ex_pkg::*;

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)                                cnt_d = CW'(1);
    else if (clr_i)                             cnt_d = '0;
    else if (en_i && (cnt_q != CW'(LIMIT)))     cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == CW'(LIMIT));
endmodule

// File: rtl/ex_dest_ctrl.sv
// ex_dest_ctrl: execute-stage controller for the destination-register path.
// Latches ID/EX control, drives the rt/rd destination mux select, sequences
// multi-cycle mult/div via md_start/md_done, and stalls ID on load-use
// hazards and while a mult/div is outstanding.
//   id_*        - instruction fields presented by ID
//   md_done     - mult/div completion pulse (ignored outside MD_WAIT)
//   dest_sel    - mux select, 0 = rt, 1 = rd
//   ex_dest     - resolved destination in EX
//   ex_valid    - EX retires an instruction this cycle
//   ex_regwrite - write enable to later stages (never set for $0)
//   md_start    - one-cycle start pulse to the mult/div unit
//   id_stall    - combinational hold of IF/ID
//   md_err      - one-cycle pulse when a mult/div times out
module ex_dest_ctrl #(
  parameter int REG_W      = 5,
  parameter int MD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic             id_regdst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_is_muldiv,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             md_done,
  output logic             dest_sel,
  output logic [REG_W-1:0] ex_dest,
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             md_start,
  output logic             id_stall
  ,
  output logic             md_err
);
  import ex_pkg::*;

  localparam logic [REG_W-1:0] ZERO = REG_W'(ZERO_REG);

  ex_state_t        state_q, state_d;
  logic             sel_q, sel_d;
  logic [REG_W-1:0] dest_q, dest_d;
  logic             rw_q, rw_d;        // latched regwrite, replayed at MD_DONE
  logic             mr_q, mr_d;        // latched memread, for load-use
  logic             vld_q, vld_d;
  logic             exrw_q, exrw_d;
  logic             start_q, start_d;
  logic             err_q, err_d;

  logic             hazard, cap, expired;
  logic [REG_W-1:0] cap_dest;

  // A load only hazards in its single RUN cycle; after that the value is
  // available by forwarding. The mult/div kind is implied by MD_WAIT, so it
  // needs no register of its own.
  assign hazard = (state_q == ST_RUN) && mr_q && exrw_q && (dest_q != ZERO) &&
                  id_valid && ((id_rs == dest_q) || (id_rt == dest_q));
  assign id_stall = (state_q == ST_MD_WAIT) || hazard;
  assign cap      = id_valid && !id_stall;
  assign cap_dest = id_regdst ? id_rd : id_rt;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dest_d  = dest_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    vld_d   = 1'b0;
    exrw_d  = 1'b0;
    start_d = 1'b0;
    err_d   = 1'b0;
    if (state_q == ST_MD_WAIT) begin
      // md_done takes priority over a coincident timeout
      if (md_done) begin
        state_d = ST_MD_DONE;
        vld_d   = 1'b1;
        exrw_d  = rw_q && (dest_q != ZERO);
      end else if (expired) begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end
    end else if (cap) begin
      sel_d  = id_regdst;
      dest_d = cap_dest;
      rw_d   = id_regwrite;
      mr_d   = id_memread;
      if (id_is_muldiv) begin
        state_d = ST_MD_WAIT;
        start_d = 1'b1;
      end else begin
        state_d = ST_RUN;
        vld_d   = 1'b1;
        exrw_d  = id_regwrite && (cap_dest != ZERO);
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      dest_q  <= '0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      vld_q   <= 1'b0;
      exrw_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dest_q  <= dest_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      vld_q   <= vld_d;
      exrw_q  <= exrw_d;
      start_q <= start_d;
      err_q   <= err_d;
    end
  end

  ex_md_timer #(.LIMIT(MD_TIMEOUT)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_d),
    .clr_i    ((state_q == ST_MD_WAIT) && (md_done || expired)),
    .en_i     ((state_q == ST_MD_WAIT) && !md_done),
    .expired_o(expired)
  );

  assign dest_sel    = sel_q;
  assign ex_dest     = dest_q;
  assign ex_valid    = vld_q;
  assign ex_regwrite = exrw_q;
  assign md_start    = start_q;
  assign md_err      = err_q;
endmodule

// File: tb/tb_ex_dest_ctrl.sv
module tb_ex_dest_ctrl;
  localparam int RW = 5;
  localparam int TO = 8;

  logic clk = 1'b0, rst_n = 1'b0;
  logic id_valid = 0, id_regdst = 0, id_regwrite = 0, id_memread = 0, id_is_muldiv = 0;
  logic [RW-1:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic md_done = 0;
  logic dest_sel, ex_valid, ex_regwrite, md_start, id_stall, md_err;
  logic [RW-1:0] ex_dest;

  ex_dest_ctrl #(.REG_W(RW), .MD_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_regdst(id_regdst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_is_muldiv(id_is_muldiv),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .md_done(md_done),
    .dest_sel(dest_sel), .ex_dest(ex_dest), .ex_valid(ex_valid),
    .ex_regwrite(ex_regwrite), .md_start(md_start), .id_stall(id_stall), .md_err(md_err)
  );

  always #5 clk = ~clk;

  typedef struct {bit v, regdst, rw, mr, md; logic [RW-1:0] rs, rt, rd; int lat;} ins_t;
  typedef struct {bit err, sel, rw; logic [RW-1:0] dest;} exp_t;

  exp_t q[$];
  ins_t dir[$];
  exp_t e;
  int total = 0, bad = 0;
  ins_t cur;
  bit have = 0, quiet = 0, mon_en = 0;
  int wait_k = 0, md_lat = 0;       // wait_k: current mult/div wait cycle, 0 = none
  bit ld_v = 0;
  logic [RW-1:0] ld_d = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(bit v, bit regdst, bit rw, bit mr, bit md,
                              int rs, int rt, int rd, int lat);
    ins_t i;
    i.v = v; i.regdst = regdst; i.rw = rw; i.mr = mr; i.md = md;
    i.rs = RW'(rs); i.rt = RW'(rt); i.rd = RW'(rd); i.lat = lat;
    return i;
  endfunction

  function automatic ins_t next_ins();
    ins_t i;
    bit md;
    if (dir.size() > 0) return dir.pop_front();
    if (quiet) return mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
    md = ($urandom_range(0, 9) == 0);
    i = mk($urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
           !md && ($urandom_range(0, 2) == 0), md, $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 11));
    return i;
  endfunction

  // One clock of front-end behaviour plus the rule-level reference model.
  // Entered at posedge+1, returns at the next posedge+1.
  task automatic step();
    bit waiting, exp_stall, acc;
    logic [RW-1:0] d;
    if (!have) begin cur = next_ins(); have = 1; end
    waiting      = (wait_k > 0);
    id_valid     = cur.v;   id_regdst = cur.regdst; id_regwrite = cur.rw;
    id_memread   = cur.mr;  id_is_muldiv = cur.md;
    id_rs        = cur.rs;  id_rt = cur.rt; id_rd = cur.rd;
    md_done      = waiting ? (wait_k == md_lat) : ($urandom_range(0, 7) == 0);
    exp_stall    = waiting || (ld_v && cur.v && (cur.rs == ld_d || cur.rt == ld_d));
    @(negedge clk);
    chk("id_stall", id_stall, exp_stall);
    chk("md_start", md_start, waiting && wait_k == 1);
    acc = cur.v && !exp_stall;
    d   = cur.regdst ? cur.rd : cur.rt;
    if (waiting) wait_k = (wait_k == md_lat || wait_k == TO) ? 0 : wait_k + 1;
    ld_v = acc && cur.mr && cur.rw && !cur.md && (d != 0);
    ld_d = d;
    if (acc) begin
      if (cur.md) begin
        md_lat = cur.lat;
        wait_k = 1;
        q.push_back('{md_lat > TO, cur.regdst, cur.rw && d != 0, d});
      end else begin
        q.push_back('{1'b0, cur.regdst, cur.rw && d != 0, d});
      end
    end
    if (acc || !cur.v) have = 0;
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: every retire or abort event consumes one expectation.
  initial forever begin
    @(negedge clk);
    if (mon_en && rst_n && (ex_valid || md_err)) begin
      if (q.size() == 0) begin
        chk("spurious_evt", {30'd0, ex_valid, md_err}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("evt_md_err", md_err, e.err);
        chk("evt_ex_valid", ex_valid, !e.err);
        if (!e.err) begin
          chk("dest_sel", dest_sel, e.sel);
          chk("ex_dest", ex_dest, e.dest);
          chk("ex_regwrite", ex_regwrite, e.rw);
        end
      end
    end
  end

  initial begin
    // reset state
    #12;
    chk("rst_dest_sel", dest_sel, 0);
    chk("rst_ex_dest", ex_dest, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_regwrite", ex_regwrite, 0);
    chk("rst_md_start", md_start, 0);
    chk("rst_md_err", md_err, 0);
    chk("rst_id_stall", id_stall, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    // directed: R-type, I-type to $0, load-use pair, md done after 4,
    // md timeout, md done coincident with the timeout cycle
    dir.push_back(mk(1, 1, 1, 0, 0, 1, 3, 9, 1));
    dir.push_back(mk(1, 0, 1, 0, 0, 2, 0, 5, 1));
    dir.push_back(mk(1, 0, 1, 1, 0, 4, 7, 6, 1));
    dir.push_back(mk(1, 1, 1, 0, 0, 7, 2, 10, 1));
    dir.push_back(mk(1, 1, 1, 0, 1, 1, 2, 12, 4));
    dir.push_back(mk(1, 1, 1, 0, 1, 1, 2, 13, 100));
    dir.push_back(mk(1, 0, 1, 0, 1, 1, 14, 3, TO));
    for (int n = 0; n < 400; n++) step();

    // drain outstanding work
    quiet = 1;
    for (int n = 0; n < 60 && (q.size() > 0 || wait_k > 0 || have); n++) step();
    step();
    chk("drain_queue", q.size(), 0);
    chk("drain_wait", wait_k, 0);

    // reset in the middle of a mult/div wait
    dir.push_back(mk(1, 1, 1, 0, 1, 1, 2, 11, 100));
    repeat (4) step();
    chk("pre_rst_stall", id_stall, 1);
    id_valid = 0;
    md_done = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ex_valid", ex_valid, 0);
    chk("mid_rst_dest", ex_dest, 0);
    chk("mid_rst_sel", dest_sel, 0);
    chk("mid_rst_regwrite", ex_regwrite, 0);
    chk("mid_rst_md_start", md_start, 0);
    chk("mid_rst_md_err", md_err, 0);
    chk("mid_rst_stall", id_stall, 0);
    q.delete(); wait_k = 0; ld_v = 0; have = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    md_done = 1;
    repeat (4) begin
      @(negedge clk);
      chk("stray_done_valid", ex_valid, 0);
      chk("stray_done_err", md_err, 0);
      chk("stray_done_stall", id_stall, 0);
    end
    md_done = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
